// File: rtl/fetch_ctrl_if.sv
// Bundles the fetch controller's signals: the instruction-memory read port, the
// decode-side valid/stall handshake and the PC redirect/halt controls.
interface fetch_ctrl_if;
  // Instruction memory read port
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_done;

  // Decode handshake and control flow
  logic        decode_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic [15:0] curr_pc;

  modport master (
    output mem_rd, mem_addr, instr, instr_pc, pc_plus2, instr_valid, curr_pc,
    input  mem_data_out, mem_done, decode_stall, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_rd, mem_addr, instr, instr_pc, pc_plus2, instr_valid, curr_pc,
    output mem_data_out, mem_done, decode_stall, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues reads to a variable-latency
// instruction memory and hands each word to decode through a registered valid/stall stage.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        pend_q, pend_d;          // a memory read is outstanding
  logic        halt_pend_q, halt_pend_d; // drain the open read, then halt
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic        issue;
  logic [15:0] fetch_addr;

  // A new read starts only from FETCH with the output slot free; qualifying with
  // rst keeps mem_rd low for the whole time reset is held.
  assign issue = rst && (state_q == FETCH) && !pend_q
              && (!valid_q || !bus.decode_stall)
              && !bus.redirect && !bus.halt;

  assign fetch_addr      = pend_q ? req_addr_q : pc_q;
  assign bus.mem_rd      = pend_q || issue;
  assign bus.mem_addr    = fetch_addr;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus2    = pc_plus2_q;
  assign bus.instr_valid = valid_q;
  assign bus.curr_pc     = pc_q;

  always_comb begin
    // NOTE: every next-state signal gets its default first so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    halt_pend_d = halt_pend_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pc_plus2_d  = pc_plus2_q;
    valid_d     = valid_q;
    pend_d      = (pend_q || issue) && !bus.mem_done;

    if (issue) req_addr_d = pc_q;

    // Decode took the held word; the slot empties unless refilled below.
    if (valid_q && !bus.decode_stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      FETCH: begin
        if (bus.halt) begin
          valid_d     = 1'b0;
          instr_d     = NOP_INSTR;
          halt_pend_d = pend_q && !bus.mem_done;
          state_d     = (pend_q && !bus.mem_done) ? DRAIN : HALTED;
        end else if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (pend_q && !bus.mem_done) state_d = DRAIN;
        end else if (bus.mem_done && (pend_q || issue)) begin
          instr_d    = bus.mem_data_out;
          instr_pc_d = fetch_addr;
          pc_plus2_d = fetch_addr + 16'd2;
          valid_d    = 1'b1;
          pc_d       = pc_q + 16'd2;
        end
      end

      DRAIN: begin
        // The read in flight belongs to a flushed path; its data is never used.
        if (bus.halt)                            halt_pend_d = 1'b1;
        else if (bus.redirect && !halt_pend_q)   pc_d        = bus.redirect_pc;
        if (bus.mem_done) begin
          state_d     = (halt_pend_q || bus.halt) ? HALTED : FETCH;
          halt_pend_d = 1'b0;
        end
      end

      HALTED: begin
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      pend_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= 16'h0000;
      pc_plus2_q  <= 16'h0002;
      valid_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      pend_q      <= pend_d;
      halt_pend_q <= halt_pend_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      pc_plus2_q  <= pc_plus2_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a latency/budget-controlled memory model plus a
// scoreboard of expected decode beats, with assertion-based checks.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } beat_t;

  logic clk;
  logic rst;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  beat_t mon_e;

  // Memory model knobs: responses need lat waiting cycles and stop once served reaches allow.
  int    lat    = 1;
  int    allow  = 0;
  int    served = 0;
  int    cnt    = 0;
  logic  stray_done = 1'b0;
  logic  prev_valid = 1'b0;
  logic  prev_stall = 1'b0;
  int    n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    if (addr == 16'h0010) return 16'h1234;
    return 16'hA000 + addr;
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [15:0] a);
    sb.push_back('{pc: a, data: mem_word(a)});
  endtask

  task automatic wait_drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < budget) begin
      sample();
      cycles++;
    end
    check16(tag, 16'(sb.size()), 16'd0);
  endtask

  task automatic wait_req(input string tag, input logic [15:0] a, input int budget);
    int k = 0;
    sample();
    while (!(bus.mem_rd && bus.mem_addr == a) && k < budget) begin
      sample();
      k++;
    end
    check1(tag, bus.mem_rd && (bus.mem_addr == a), 1'b1);
  endtask

  task automatic reset_dut();
    check16("sb_empty_before_reset", 16'(sb.size()), 16'd0);
    rst              = 1'b0;
    bus.halt         = 1'b0;
    bus.redirect     = 1'b0;
    bus.decode_stall = 1'b0;
    stray_done       = 1'b0;
    repeat (2) step();
  endtask

  // Memory model
  initial begin
    bus.mem_done     = 1'b0;
    bus.mem_data_out = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.mem_done = 1'b0;
        cnt          = 0;
      end else begin
        if (bus.mem_done) begin
          bus.mem_done = 1'b0;
          cnt          = 0;
        end
        if (stray_done) begin
          bus.mem_done     = 1'b1;
          bus.mem_data_out = 16'hDEAD;
        end else if (bus.mem_rd) begin
          if (cnt >= lat && served < allow) begin
            bus.mem_done     = 1'b1;
            bus.mem_data_out = mem_word(bus.mem_addr);
            served++;
          end else if (cnt < 1000) begin
            cnt++;
          end
        end
      end
    end
  end

  // Output monitor: a new beat is a valid word that was not held over from a stalled cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (bus.instr_valid && (!prev_valid || !prev_stall)) begin
          check1("beat_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check16("beat_pc", bus.instr_pc, mon_e.pc);
            check16("beat_instr", bus.instr, mon_e.data);
            check16("beat_pc_plus2", bus.pc_plus2, mon_e.pc + 16'd2);
          end
        end
        prev_valid = bus.instr_valid;
        prev_stall = bus.decode_stall;
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.decode_stall = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0000;
    bus.halt         = 1'b0;
    #1 rst = 1'b0;
    #1;

    check1 ("rst_valid",    bus.instr_valid, 1'b0);
    check16("rst_instr",    bus.instr,       16'h0800);
    check16("rst_instr_pc", bus.instr_pc,    16'h0000);
    check16("rst_pc_plus2", bus.pc_plus2,    16'h0002);
    check1 ("rst_mem_rd",   bus.mem_rd,      1'b0);
    check16("rst_curr_pc",  bus.curr_pc,     16'h0000);

    // 1: back-to-back fetches, one-cycle memory
    lat   = 1;
    allow = served + 4;
    expect_fetch(16'h0000);
    expect_fetch(16'h0002);
    expect_fetch(16'h0004);
    expect_fetch(16'h0006);
    step();
    rst = 1'b1;
    sample();
    check1 ("t1_first_rd",   bus.mem_rd,   1'b1);
    check16("t1_first_addr", bus.mem_addr, 16'h0000);
    wait_drain("t1_drain", 40, n);
    check16("t1_cycles", 16'(n), 16'd8);
    repeat (3) sample();
    check1 ("t1_hang_rd",   bus.mem_rd,      1'b1);
    check16("t1_hang_addr", bus.mem_addr,    16'h0008);
    check16("t1_curr_pc",   bus.curr_pc,     16'h0008);
    check1 ("t1_valid_low", bus.instr_valid, 1'b0);

    // 2: three-cycle memory latency
    reset_dut();
    lat   = 3;
    allow = served + 3;
    expect_fetch(16'h0000);
    expect_fetch(16'h0002);
    expect_fetch(16'h0004);
    rst = 1'b1;
    wait_req("t2_req4", 16'h0004, 30);
    repeat (3) begin
      sample();
      check1 ("t2_rd_hold",   bus.mem_rd,      1'b1);
      check16("t2_addr_hold", bus.mem_addr,    16'h0004);
      check1 ("t2_valid_low", bus.instr_valid, 1'b0);
    end
    wait_drain("t2_drain", 20, n);

    // 3: decode stall holds the output register
    reset_dut();
    allow            = served;
    bus.decode_stall = 1'b1;
    rst              = 1'b1;
    repeat (2) sample();
    check1("t3_hang_rd", bus.mem_rd, 1'b1);
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    step();
    bus.redirect = 1'b0;
    lat   = 1;
    allow = served + 2;
    expect_fetch(16'h0010);
    n = 0;
    sample();
    while (!bus.instr_valid && n < 20) begin
      sample();
      n++;
    end
    check1("t3_valid", bus.instr_valid, 1'b1);
    repeat (4) begin
      sample();
      check1 ("t3_hold_valid",  bus.instr_valid, 1'b1);
      check16("t3_hold_instr",  bus.instr,       16'h1234);
      check16("t3_hold_pc",     bus.instr_pc,    16'h0010);
      check16("t3_hold_plus2",  bus.pc_plus2,    16'h0012);
      check1 ("t3_hold_no_rd",  bus.mem_rd,      1'b0);
      check16("t3_hold_curr",   bus.curr_pc,     16'h0012);
    end
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    sample();
    check16("t3_stray_instr", bus.instr,   16'h1234);
    check16("t3_stray_curr",  bus.curr_pc, 16'h0012);
    check1 ("t3_stray_no_rd", bus.mem_rd,  1'b0);
    step();
    allow = served + 1;
    expect_fetch(16'h0012);
    bus.decode_stall = 1'b0;
    sample();
    check1 ("t3_next_rd",   bus.mem_rd,   1'b1);
    check16("t3_next_addr", bus.mem_addr, 16'h0012);
    wait_drain("t3_drain", 20, n);

    // 4: redirect while a read is in flight
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0020;
    step();
    bus.redirect = 1'b0;
    allow = served + 1;
    wait_req("t4_req20", 16'h0020, 20);
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    step();
    bus.redirect = 1'b0;
    repeat (2) begin
      sample();
      check1 ("t4_valid_low", bus.instr_valid, 1'b0);
      check1 ("t4_drain_rd",  bus.mem_rd,      1'b1);
      check16("t4_drain_addr", bus.mem_addr,   16'h0020);
      check16("t4_curr_pc",   bus.curr_pc,     16'h0100);
    end
    lat   = 3;
    allow = served + 2;
    expect_fetch(16'h0100);
    wait_drain("t4_drain", 30, n);

    // 5: wrap at the top of the address space, then redirect coinciding with mem_done
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect = 1'b0;
    lat   = 1;
    allow = served + 2;
    expect_fetch(16'hFFFE);
    wait_drain("t5_drain", 20, n);
    repeat (3) sample();
    check1 ("t5_wrap_rd",   bus.mem_rd,   1'b1);
    check16("t5_wrap_addr", bus.mem_addr, 16'h0000);
    check16("t5_wrap_pc",   bus.curr_pc,  16'h0000);
    step();
    allow = served + 1;
    n = 0;
    sample();
    while (!bus.mem_done && n < 10) begin
      sample();
      n++;
    end
    check1("t5_done_seen", bus.mem_done, 1'b1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    step();
    bus.redirect = 1'b0;
    sample();
    check1 ("t5_redir_rd",    bus.mem_rd,      1'b1);
    check16("t5_redir_addr",  bus.mem_addr,    16'h0200);
    check1 ("t5_redir_valid", bus.instr_valid, 1'b0);
    check16("t5_redir_pc",    bus.curr_pc,     16'h0200);

    // 6: halt with a read in flight, then asynchronous reset mid-request
    step();
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    allow = served + 1;
    sample();
    check1 ("t6_drain_rd",   bus.mem_rd,      1'b1);
    check16("t6_drain_addr", bus.mem_addr,    16'h0200);
    check1 ("t6_valid_low",  bus.instr_valid, 1'b0);
    sample();
    check1 ("t6_halted_rd",    bus.mem_rd,  1'b0);
    check16("t6_halted_pc",    bus.curr_pc, 16'h0200);
    check16("t6_halted_instr", bus.instr,   16'h0800);
    step();
    bus.redirect     = 1'b1;
    bus.redirect_pc  = 16'h0300;
    bus.decode_stall = 1'b1;
    allow            = served + 5;
    step();
    bus.redirect     = 1'b0;
    bus.decode_stall = 1'b0;
    repeat (4) begin
      sample();
      check1 ("t6_stay_rd",    bus.mem_rd,      1'b0);
      check16("t6_stay_pc",    bus.curr_pc,     16'h0200);
      check1 ("t6_stay_valid", bus.instr_valid, 1'b0);
    end

    reset_dut();
    allow = served;
    rst   = 1'b1;
    repeat (2) sample();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0400;
    step();
    bus.redirect = 1'b0;
    allow = served + 1;
    wait_req("t6_req400", 16'h0400, 10);
    check16("t6_pre_rst_pc", bus.curr_pc, 16'h0400);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check1 ("t6_arst_rd",    bus.mem_rd,      1'b0);
    check16("t6_arst_pc",    bus.curr_pc,     16'h0000);
    check16("t6_arst_addr",  bus.mem_addr,    16'h0000);
    check1 ("t6_arst_valid", bus.instr_valid, 1'b0);
    check16("t6_arst_instr", bus.instr,       16'h0800);
    step();
    lat   = 1;
    allow = served + 2;
    expect_fetch(16'h0000);
    expect_fetch(16'h0002);
    rst = 1'b1;
    wait_drain("t6_restart", 20, n);

    repeat (2) sample();
    check16("sb_empty_at_end", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller that reads the program counter and issues reads to a variable-latency instruction memory.
- Returns each fetched instruction to decode through a registered valid/stall handshake.
- Owns the architectural PC register: increments it on each fetch and loads it on branch/jump redirect.
- Sits between the PC and the instruction memory (upstream) and decode (downstream).

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, value driven on instr whenever instr_valid=0

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
mem_data_out  in  16  instruction word from memory; valid only when mem_done=1
mem_done  in  1  one-cycle pulse: read request complete
mem_rd  out  1  read request; held high until mem_done
mem_addr  out  16  read address; stable while mem_rd=1
decode_stall  in  1  decode cannot accept; hold output register
redirect  in  1  load redirect_pc into PC and flush
redirect_pc  in  16  branch/jump target
halt  in  1  stop fetching permanently until reset
instr  out  16  fetched instruction (registered)
instr_pc  out  16  address of instr
pc_plus2  out  16  instr_pc+2, mod 2^16
instr_valid  out  1  instr/instr_pc/pc_plus2 meaningful
curr_pc  out  16  current PC register value

Behaviour:
- States: FETCH, DRAIN, HALTED.
- Reset (rst=0, asynchronous) forces:
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0, pc_plus2=2, mem_rd=0.
- FETCH:
  - mem_rd=1 when (no request outstanding) and (instr_valid=0 or decode_stall=0).
  - On issue, req_addr<=pc. mem_addr=req_addr while the request is outstanding, else pc.
  - Once asserted, mem_rd stays high with the same mem_addr until mem_done, regardless of decode_stall.
- mem_done in FETCH (no redirect/halt):
  - Next cycle: instr<=mem_data_out, instr_pc<=req_addr, pc_plus2<=req_addr+2, instr_valid<=1, pc<=pc+2.
  - Best case: one instruction every 2 cycles (request cycle, then done). mem_done in the issue cycle is legal and yields 1-cycle throughput.
- Output register:
  - Held unchanged while instr_valid=1 and decode_stall=1.
  - Clears to instr_valid=0 (instr=NOP_INSTR) after decode consumes it (decode_stall=0) and no new data arrives that cycle.
- Redirect (priority below halt, above everything else):
  - pc<=redirect_pc; instr_valid<=0.
  - No request outstanding, or mem_done the same cycle: data discarded, stay FETCH.
  - Request outstanding without mem_done: go DRAIN.
- DRAIN:
  - mem_rd=1, mem_addr=req_addr until mem_done; returned data discarded; then FETCH (new request issued next cycle).
  - A further redirect in DRAIN updates pc and stays in DRAIN.
- halt:
  - instr_valid<=0; no new request issued.
  - If a request is outstanding, keep mem_rd until mem_done, discard the data, then HALTED.
  - Otherwise go HALTED next cycle.
  - HALTED: mem_rd=0, pc frozen; redirect and decode_stall ignored; exit only by reset.
- Arithmetic: pc+2 and req_addr+2 wrap modulo 2^16 (16'hFFFE -> 16'h0000). Bit 0 of redirect_pc is passed through unchanged.
- Reset asserted mid-request: all state cleared immediately; the pending mem_done after reset release is ignored, because mem_done is qualified by an outstanding-request flag cleared on reset.
- mem_done with no outstanding request: ignored.

Test Plan:
1. Reset release, memory returns mem_done 1 cycle after each request, data 16'hA000+addr -> instr_pc sequence 0,2,4,6, instr 16'hA000,16'hA002,...; pc_plus2=instr_pc+2.
2. Memory latency 3 cycles -> mem_rd and mem_addr=0x0004 held stable for 3 cycles; instr_valid rises exactly once per mem_done.
3. decode_stall=1 for 4 cycles with instr_valid=1 (instr 0x1234 at pc 0x0010) -> outputs unchanged, no new mem_rd, pc=0x0012; after release, the next fetch at 0x0012 is issued.
4. redirect to 0x0100 one cycle after a request to 0x0020 is issued (latency 3) -> instr_valid=0, DRAIN holds mem_addr=0x0020 until done, data dropped, next request at 0x0100.
5. Redirect to 0xFFFE -> fetch 0xFFFE, pc_plus2=0x0000, next fetch at 0x0000. Redirect and mem_done in the same cycle -> data dropped, next mem_addr=redirect_pc.
6. halt while a request is outstanding -> request completes and is dropped, then mem_rd=0 forever and redirect is ignored. rst pulsed low mid-request -> mem_rd=0 and curr_pc=RESET_PC immediately, without waiting for a clock edge.
